// File: rtl/mips_cpu_bus_core.sv
// Multicycle MIPS-I subset CPU on a single Avalon-style bus: FETCH -> EXEC -> (MEM) -> FETCH.
// One delay slot is modelled by carrying the next fetch address (npc) alongside the PC.
module mips_cpu_bus_core (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [2:0] {S_RESET, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, npc_q, npc_d, ir_q, ir_d;
  logic [31:0] maddr_q, maddr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] gpr_q [32];

  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_val;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sh;
  logic [31:0] rs_v, rt_v, simm, zimm, ea, pc4, brt, jt;
  logic        is_load, is_store;
  logic [7:0]  ld_byte;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign sh    = ir_q[10:6];
  assign funct = ir_q[5:0];
  assign rs_v  = gpr_q[rs];
  assign rt_v  = gpr_q[rt];
  assign simm  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zimm  = {16'd0, ir_q[15:0]};
  assign ea    = rs_v + simm;
  assign pc4   = pc_q + 32'd4;
  assign brt   = pc4 + {simm[29:0], 2'b00};
  assign jt    = {pc4[31:28], ir_q[25:0], 2'b00};

  assign is_load  = (op == 6'h23) || (op == 6'h20) || (op == 6'h24);
  assign is_store = (op == 6'h2B) || (op == 6'h28);

  assign register_v0 = gpr_q[2];

  always_comb begin
    ld_byte = readdata[7:0];
    case (maddr_q[1:0])
      2'd1:    ld_byte = readdata[15:8];
      2'd2:    ld_byte = readdata[23:16];
      2'd3:    ld_byte = readdata[31:24];
      default: ld_byte = readdata[7:0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    ir_d       = ir_q;
    maddr_d    = maddr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    wr_en      = 1'b0;
    wr_idx     = 5'd0;
    wr_val     = 32'd0;
    read       = 1'b0;
    write      = 1'b0;
    address    = pc_q;
    byteenable = 4'h0;
    writedata  = 32'd0;
    active     = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEM);

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        read       = 1'b1;
        byteenable = 4'hF;
        if (!waitrequest) begin
          ir_d    = readdata;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        pc_d  = npc_q;
        npc_d = npc_q + 32'd4;
        case (op)
          6'h00: begin
            wr_idx = rd;
            wr_en  = 1'b1;
            case (funct)
              6'h00:   wr_val = rt_v << sh;
              6'h02:   wr_val = rt_v >> sh;
              6'h03:   wr_val = $signed(rt_v) >>> sh;
              6'h08:   begin wr_en = 1'b0; npc_d = rs_v; end
              6'h09:   begin wr_val = pc_q + 32'd8; npc_d = rs_v; end
              6'h21:   wr_val = rs_v + rt_v;
              6'h23:   wr_val = rs_v - rt_v;
              6'h24:   wr_val = rs_v & rt_v;
              6'h25:   wr_val = rs_v | rt_v;
              6'h26:   wr_val = rs_v ^ rt_v;
              6'h2A:   wr_val = {31'd0, $signed(rs_v) < $signed(rt_v)};
              6'h2B:   wr_val = {31'd0, rs_v < rt_v};
              default: wr_en = 1'b0;
            endcase
          end
          6'h09: begin wr_en = 1'b1; wr_idx = rt; wr_val = rs_v + simm; end
          6'h0A: begin wr_en = 1'b1; wr_idx = rt; wr_val = {31'd0, $signed(rs_v) < $signed(simm)}; end
          6'h0B: begin wr_en = 1'b1; wr_idx = rt; wr_val = {31'd0, rs_v < simm}; end
          6'h0C: begin wr_en = 1'b1; wr_idx = rt; wr_val = rs_v & zimm; end
          6'h0D: begin wr_en = 1'b1; wr_idx = rt; wr_val = rs_v | zimm; end
          6'h0E: begin wr_en = 1'b1; wr_idx = rt; wr_val = rs_v ^ zimm; end
          6'h0F: begin wr_en = 1'b1; wr_idx = rt; wr_val = {ir_q[15:0], 16'd0}; end
          6'h04: if (rs_v == rt_v) npc_d = brt;
          6'h05: if (rs_v != rt_v) npc_d = brt;
          6'h02: npc_d = jt;
          6'h03: begin npc_d = jt; wr_en = 1'b1; wr_idx = 5'd31; wr_val = pc_q + 32'd8; end
          default: ;
        endcase
        // Byte accesses select one lane; word accesses just drop the low address bits.
        maddr_d = ea;
        if (op == 6'h20 || op == 6'h24 || op == 6'h28) be_d = 4'b0001 << ea[1:0];
        else                                         be_d = 4'hF;
        wdata_d = (op == 6'h28) ? {4{rt_v[7:0]}} : rt_v;
        if (is_load || is_store)   state_d = S_MEM;
        else if (npc_q == 32'd0)   state_d = S_HALT;
        else                       state_d = S_FETCH;
      end

      S_MEM: begin
        address    = {maddr_q[31:2], 2'b00};
        byteenable = be_q;
        if (is_store) begin
          write     = 1'b1;
          writedata = wdata_q;
        end else begin
          read = 1'b1;
        end
        if (!waitrequest) begin
          if (is_load) begin
            wr_en  = 1'b1;
            wr_idx = rt;
            case (op)
              6'h20:   wr_val = {{24{ld_byte[7]}}, ld_byte};
              6'h24:   wr_val = {24'd0, ld_byte};
              default: wr_val = readdata;
            endcase
          end
          state_d = (pc_q == 32'd0) ? S_HALT : S_FETCH;
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      pc_q    <= RESET_VEC;
      npc_q   <= RESET_VEC + 32'd4;
      ir_q    <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      ir_q    <= ir_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      if (wr_en && wr_idx != 5'd0) gpr_q[wr_idx] <= wr_val;
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_core.sv
// Directed program tests for mips_cpu_bus_core against a small ROM/RAM bus model with injectable stalls.
module tb_mips_cpu_bus_core;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active, write, read, waitrequest;
  logic [31:0] register_v0, address, writedata, readdata;
  logic [3:0]  byteenable;

  mips_cpu_bus_core dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .address(address), .write(write), .read(read), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [64];
  logic [31:0] ram [256];
  logic [31:0] sa0, sa1;
  int          sn0, sn1;
  int          wr_cnt;
  logic [3:0]  last_be;
  logic [31:0] last_wd, last_wa;
  int          n_chk = 0, n_fail = 0;

  assign waitrequest = (read || write) &&
                       ((address == sa0 && sn0 > 0) || (address == sa1 && sn1 > 0));
  assign readdata = (address[31:28] == 4'hB) ? rom[address[7:2]] : ram[address[9:2]];

  always @(posedge clk) begin
    if (write && !waitrequest) begin
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) ram[address[9:2]][8*i +: 8] <= writedata[8*i +: 8];
      wr_cnt  <= wr_cnt + 1;
      last_be <= byteenable;
      last_wd <= writedata;
      last_wa <= address;
    end
    if (waitrequest) begin
      if (address == sa0 && sn0 > 0) sn0 <= sn0 - 1;
      else                           sn1 <= sn1 - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Value history of $v0, a write-of-99 detector, and bus stability during stalls.
  logic [31:0] hist [$];
  logic [31:0] last_v0 = 32'd0;
  logic        seen99 = 1'b0;
  logic        was_wait = 1'b0;
  logic [31:0] p_addr, p_wd;
  logic [31:0] p_ctl;
  always @(negedge clk) begin
    if (reset) last_v0 = 32'd0;
    else begin
      if (register_v0 !== last_v0) begin hist.push_back(register_v0); last_v0 = register_v0; end
      if (register_v0 == 32'd99) seen99 = 1'b1;
    end
    if (waitrequest && was_wait) begin
      chk("stall_addr", address, p_addr);
      chk("stall_wdata", writedata, p_wd);
      chk("stall_ctl", {26'd0, byteenable, read, write}, p_ctl);
    end
    if (read && write) chk("rd_wr_excl", {31'd0, read && write}, 32'd0);
    was_wait = waitrequest;
    p_addr   = address;
    p_wd     = writedata;
    p_ctl    = {26'd0, byteenable, read, write};
  end

  task automatic load_rom(input logic [31:0] p [$]);
    for (int i = 0; i < 64; i++) rom[i] = (i < p.size()) ? p[i] : 32'd0;
  endtask

  task automatic start_prog();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    hist.delete();
    seen99 = 1'b0;
  endtask

  // Releases reset and counts active cycles until halt.
  task automatic run_to_halt(input string tag, output int cyc);
    reset = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (active && cyc < 400) begin cyc++; @(negedge clk); end
    chk({tag, "_timeout"}, {31'd0, cyc < 400}, 32'd1);
  endtask

  int cyc, w0, bound;

  initial begin
    sa0 = 32'hFFFF_FFFF; sa1 = 32'hFFFF_FFFF; sn0 = 0; sn1 = 0; wr_cnt = 0;
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;

    // P1: addiu $2,$0,5 ; jr $0 ; nop
    load_rom('{32'h24020005, 32'h00000008, 32'h00000000});
    start_prog();
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_be", {28'd0, byteenable}, 32'd0);
    chk("rst_wdata", writedata, 32'd0);
    chk("rst_addr", address, 32'hBFC00000);
    chk("rst_v0", register_v0, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("first_active", {31'd0, active}, 32'd1);
    chk("first_read", {31'd0, read}, 32'd1);
    chk("first_addr", address, 32'hBFC00000);
    cyc = 1;
    @(negedge clk);
    while (active && cyc < 400) begin cyc++; @(negedge clk); end
    chk("p1_cycles", cyc, 32'd6);
    chk("p1_v0", register_v0, 32'd5);
    for (int i = 0; i < 4; i++) begin
      chk("halt_read", {31'd0, read}, 32'd0);
      chk("halt_write", {31'd0, write}, 32'd0);
      chk("halt_active", {31'd0, active}, 32'd0);
      @(negedge clk);
    end

    // P2: lui $2,0x1234 ; ori $2,$2,0x5678
    load_rom('{32'h3C021234, 32'h34425678, 32'h00000008, 32'h00000000});
    start_prog();
    run_to_halt("p2", cyc);
    chk("p2_cycles", cyc, 32'd8);
    chk("p2_v0", register_v0, 32'h12345678);

    // P3: sw / sb / lw
    load_rom('{32'h3C03AABB, 32'h3463CCDD, 32'hAC030100, 32'h24040011,
               32'hA0040102, 32'h8C020100, 32'h00000008, 32'h00000000});
    ram[64] = 32'd0;
    start_prog();
    w0 = wr_cnt;
    run_to_halt("p3", cyc);
    chk("p3_cycles", cyc, 32'd19);
    chk("p3_v0", register_v0, 32'hAA11CCDD);
    chk("p3_mem", ram[64], 32'hAA11CCDD);
    chk("p3_nwrites", wr_cnt - w0, 32'd2);
    chk("sb_be", {28'd0, last_be}, 32'h4);
    chk("sb_wdata", last_wd, 32'h11111111);
    chk("sb_addr", last_wa, 32'h100);

    // P4: lb then lbu of a 0x80 byte at 0x201
    load_rom('{32'h80020201, 32'h90020201, 32'h00000008, 32'h00000000});
    ram[128] = 32'h00008000;
    start_prog();
    run_to_halt("p4", cyc);
    chk("p4_cycles", cyc, 32'd10);
    chk("p4_nhist", hist.size(), 32'd2);
    if (hist.size() == 2) begin
      chk("lb_sext", hist[0], 32'hFFFFFF80);
      chk("lbu_zext", hist[1], 32'h00000080);
    end

    // P5: beq taken, delay slot increments, skipped instruction writes 99
    load_rom('{32'h24020001, 32'h10000002, 32'h24420001, 32'h24020063,
               32'h00000008, 32'h00000000});
    start_prog();
    run_to_halt("p5", cyc);
    chk("p5_cycles", cyc, 32'd10);
    chk("p5_v0", register_v0, 32'd2);
    chk("p5_no99", {31'd0, seen99}, 32'd0);
    chk("p5_nhist", hist.size(), 32'd2);

    // P6: jal over a 99-write, then copy $31 into $2
    load_rom('{32'h0FF00004, 32'h00000000, 32'h24020063, 32'h24020063,
               32'h03E01021, 32'h00000008, 32'h00000000});
    start_prog();
    run_to_halt("p6", cyc);
    chk("p6_cycles", cyc, 32'd10);
    chk("jal_link", register_v0, 32'hBFC00008);
    chk("p6_no99", {31'd0, seen99}, 32'd0);

    // P7: addiu $3,-1 ; slt ; sra 4 ; srl 28
    load_rom('{32'h2403FFFF, 32'h0060102A, 32'h00031103, 32'h00031702,
               32'h00000008, 32'h00000000});
    start_prog();
    run_to_halt("p7", cyc);
    chk("p7_nhist", hist.size(), 32'd3);
    if (hist.size() == 3) begin
      chk("slt_neg", hist[0], 32'd1);
      chk("sra", hist[1], 32'hFFFFFFFF);
      chk("srl", hist[2], 32'h0000000F);
    end

    // P8: P3 again with 3-cycle stalls on the first fetch and on the word store
    load_rom('{32'h3C03AABB, 32'h3463CCDD, 32'hAC030100, 32'h24040011,
               32'hA0040102, 32'h8C020100, 32'h00000008, 32'h00000000});
    ram[64] = 32'd0;
    start_prog();
    sa0 = 32'hBFC00000; sn0 = 3;
    sa1 = 32'h00000100; sn1 = 3;
    run_to_halt("p8", cyc);
    chk("p8_cycles", cyc, 32'd25);
    chk("p8_v0", register_v0, 32'hAA11CCDD);
    chk("p8_mem", ram[64], 32'hAA11CCDD);

    // P9: reset during a stalled fetch
    load_rom('{32'h24020005, 32'h00000008, 32'h00000000});
    start_prog();
    sa0 = 32'hBFC00000; sn0 = 10; sn1 = 0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("p9_stalled", {31'd0, waitrequest && read}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("p9_rst_read", {31'd0, read}, 32'd0);
    chk("p9_rst_active", {31'd0, active}, 32'd0);
    sn0 = 0;
    reset = 1'b0;
    @(negedge clk);
    chk("p9_refetch_read", {31'd0, read}, 32'd1);
    chk("p9_refetch_addr", address, 32'hBFC00000);
    bound = 0;
    while (active && bound < 400) begin bound++; @(negedge clk); end
    chk("p9_v0", register_v0, 32'd5);

    // P10: reset during a stalled word store
    load_rom('{32'h3C03AABB, 32'h3463CCDD, 32'hAC030100, 32'h24040011,
               32'hA0040102, 32'h8C020100, 32'h00000008, 32'h00000000});
    ram[64] = 32'd0;
    start_prog();
    sa0 = 32'hFFFFFFFF; sa1 = 32'h00000100; sn1 = 20;
    reset = 1'b0;
    bound = 0;
    @(negedge clk);
    while (!write && bound < 50) begin bound++; @(negedge clk); end
    chk("p10_store_seen", {31'd0, write && waitrequest}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("p10_write_drop", {31'd0, write}, 32'd0);
    sn1 = 0;
    @(negedge clk);
    chk("p10_no_commit", ram[64], 32'd0);
    chk("p10_write_low", {31'd0, write}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
